// File: rtl/lru_unique_tracker.sv
// lru_unique_tracker: most-recent-first history of the NUM latest distinct values with move-to-front,
// plus hit/index, eviction and occupancy reporting.
module lru_unique_tracker #(
    parameter int WIDTH = 8,
    parameter int NUM = 4,
    localparam int IW = $clog2(NUM),
    localparam int CW = $clog2(NUM + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       clear_in,
    output logic [NUM-1:0][WIDTH-1:0]  out,
    output logic [NUM-1:0]             out_valid,
    output logic [CW-1:0]              count_out,
    output logic                       hit_out,
    output logic [IW-1:0]              hit_idx_out,
    output logic                       evict_valid_out,
    output logic [WIDTH-1:0]           evict_data_out
);
    logic [NUM-1:0]            match;
    logic                      hit;
    logic                      accept;
    logic [IW-1:0]             m;
    logic [NUM-1:0][WIDTH-1:0] data_nxt;

    always_comb begin
        accept = in_valid && !clear_in;
        m = '0;
        match = '0;
        for (int k = 0; k < NUM; k++) begin
            match[k] = out_valid[k] && out[k] == data_in;
            m = match[k] ? IW'(k) : m;
        end
        hit = |match;
        // a miss shifts every slot; a hit shifts only slots up to the match
        data_nxt[0] = accept ? data_in : out[0];
        for (int k = 1; k < NUM; k++)
            data_nxt[k] = (accept && (!hit || IW'(k) <= m)) ? out[k-1] : out[k];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out             <= '0;
            out_valid       <= '0;
            count_out       <= '0;
            hit_out         <= 1'b0;
            hit_idx_out     <= '0;
            evict_valid_out <= 1'b0;
            evict_data_out  <= '0;
        end else begin
            out             <= data_nxt;
            hit_out         <= accept && hit;
            evict_valid_out <= accept && !hit && out_valid[NUM-1];
            hit_idx_out     <= (accept && hit) ? m : hit_idx_out;
            evict_data_out  <= (accept && !hit && out_valid[NUM-1]) ? out[NUM-1] : evict_data_out;
            out_valid       <= clear_in ? '0 : (accept && !hit) ? {out_valid[NUM-2:0], 1'b1} : out_valid;
            count_out       <= clear_in ? '0 :
                               (accept && !hit && count_out != CW'(NUM)) ? count_out + 1'b1 : count_out;
        end
    end
endmodule

// File: tb/tb_lru_unique_tracker.sv
// tb_lru_unique_tracker: directed and randomized checks against a queue-based move-to-front model.
module tb_lru_unique_tracker;
    localparam int WIDTH = 8;
    localparam int NUM = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic [WIDTH-1:0]          data_in = '0;
    logic                      clear_in = 1'b0;
    logic [NUM-1:0][WIDTH-1:0] out;
    logic [NUM-1:0]            out_valid;
    logic [2:0]                count_out;
    logic                      hit_out;
    logic [1:0]                hit_idx_out;
    logic                      evict_valid_out;
    logic [WIDTH-1:0]          evict_data_out;

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] q[$];
    logic             exp_hit = 1'b0;
    logic             exp_ev = 1'b0;
    int               exp_idx = 0;
    logic [WIDTH-1:0] exp_evd = '0;

    lru_unique_tracker #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .data_in(data_in), .clear_in(clear_in),
        .out(out), .out_valid(out_valid), .count_out(count_out), .hit_out(hit_out),
        .hit_idx_out(hit_idx_out), .evict_valid_out(evict_valid_out), .evict_data_out(evict_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_hit = 1'b0;
        exp_ev = 1'b0;
        exp_idx = 0;
        exp_evd = '0;
    endtask

    task automatic model(input logic v, input logic [WIDTH-1:0] d, input logic c);
        int f;
        exp_hit = 1'b0;
        exp_ev = 1'b0;
        if (c) q.delete();
        else if (v) begin
            f = -1;
            foreach (q[i]) if (q[i] == d) f = i;
            if (f >= 0) begin
                exp_hit = 1'b1;
                exp_idx = f;
                q.delete(f);
            end else if (q.size() == NUM) begin
                exp_ev = 1'b1;
                exp_evd = q[NUM-1];
                void'(q.pop_back());
            end
            q.push_front(d);
        end
    endtask

    task automatic check_all();
        logic [NUM-1:0] ev;
        ev = NUM'((1 << q.size()) - 1);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("count", 32'(count_out), 32'(q.size()));
        chk("hit", 32'(hit_out), 32'(exp_hit));
        chk("hit_idx", 32'(hit_idx_out), 32'(exp_idx));
        chk("evict_valid", 32'(evict_valid_out), 32'(exp_ev));
        chk("evict_data", 32'(evict_data_out), 32'(exp_evd));
        foreach (q[i]) chk($sformatf("slot%0d", i), 32'(out[i]), 32'(q[i]));
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_hit", 32'(hit_out), 0);
        chk("rst_idx", 32'(hit_idx_out), 0);
        chk("rst_ev", 32'(evict_valid_out), 0);
        chk("rst_evd", 32'(evict_data_out), 0);
        for (int i = 0; i < NUM; i++) chk("rst_out", 32'(out[i]), 0);
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c);
        in_valid = v;
        data_in = d;
        clear_in = c;
        @(posedge clk);
        model(v, d, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [WIDTH-1:0] alpha [6];
        alpha = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        #12;
        check_reset();
        rst = 1'b0;
        model_reset();
        // A,B,C
        step(1, 8'hA1, 0); step(1, 8'hB2, 0); step(1, 8'hC3, 0);
        chk("abc_valid", 32'(out_valid), 32'h7);
        chk("abc_slot0", 32'(out[0]), 32'hC3);
        chk("abc_slot2", 32'(out[2]), 32'hA1);
        // fill then evict A
        step(1, 8'hD4, 0); step(1, 8'hE5, 0);
        chk("evict_a", 32'(evict_data_out), 32'hA1);
        chk("evict_pulse", 32'(evict_valid_out), 1);
        chk("evict_slot3", 32'(out[3]), 32'hB2);
        // clear together with valid, then stale slot-3 value is a miss
        step(1, 8'hE5, 1);
        chk("clr_count", 32'(count_out), 0);
        step(1, 8'hB2, 0);
        chk("stale_miss", 32'(hit_out), 0);
        chk("stale_valid", 32'(out_valid), 1);
        // move-to-front from D,C,B,A
        step(0, 8'h00, 1);
        step(1, 8'hA1, 0); step(1, 8'hB2, 0); step(1, 8'hC3, 0); step(1, 8'hD4, 0);
        step(1, 8'hB2, 0);
        chk("mtf_idx", 32'(hit_idx_out), 2);
        chk("mtf_slot1", 32'(out[1]), 32'hD4);
        chk("mtf_slot3", 32'(out[3]), 32'hA1);
        step(1, 8'hB2, 0);
        chk("rep_idx", 32'(hit_idx_out), 0);
        chk("rep_hit", 32'(hit_out), 1);
        // idle
        for (int i = 0; i < 5; i++) step(0, 8'($urandom), 0);
        // async reset mid-period
        #2 rst = 1'b1;
        #1 check_reset();
        model_reset();
        #2 rst = 1'b0;
        step(1, 8'hB2, 0);
        chk("post_rst_miss", 32'(hit_out), 0);
        // random stream
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                #2 rst = 1'b1;
                #1 check_reset();
                model_reset();
                #2 rst = 1'b0;
            end
            step($urandom_range(0, 9) < 8, alpha[$urandom_range(0, 5)], $urandom_range(0, 39) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lru_unique_tracker.md
# lru_unique_tracker

Keeps the NUM most recently seen distinct WIDTH-bit values, ordered most-recent-first, with true move-to-front on a repeat. It is the next generation of the last-N-unique history block: it adds an input valid qualifier, asynchronous reset, synchronous clear, hit/miss and hit-index reporting, eviction reporting and an occupancy count. It sits on a sampled data stream and feeds downstream logic that needs a de-duplicated recent history.

## Interface

Parameters:
- WIDTH, 8, bit width of each tracked value
- NUM, 4, number of history slots; legal range NUM >= 2
- IW, $clog2(NUM), index width (derived, not overridden)
- CW, $clog2(NUM+1), count width (derived, not overridden)

Ports:
- clk_in  input  1  single clock, rising edge
- rst_in  input  1  reset, asynchronous, active-high
- in_valid  input  1  data_in is presented this cycle
- data_in  input  WIDTH  value to record
- clear_in  input  1  synchronous flush of all history
- out  output  [NUM-1:0][WIDTH-1:0]  history; slot 0 is most recent
- out_valid  output  NUM  per-slot occupancy; always thermometer-coded from bit 0
- count_out  output  CW  number of valid slots, 0..NUM
- hit_out  output  1  pulse: previous accepted input matched a valid slot
- hit_idx_out  output  IW  slot index the match was found in, before the update
- evict_valid_out  output  1  pulse: previous accepted miss pushed out a valid slot NUM-1
- evict_data_out  output  WIDTH  value evicted

## Operation

- Compare: data_in is compared against every slot k where out_valid[k]=1. At most one slot can match, because entries are unique by construction. The match index m is a one-hot-to-binary encode.
- Hit, with in_valid=1 and match at m:
  - slots 1..m load slot k-1
  - slot 0 loads data_in
  - slots above m are unchanged
  - out_valid and count are unchanged
  - hit_out=1, hit_idx_out=m
  - m=0 is legal: there is no visible change apart from the hit pulse.
- Miss, with in_valid=1 and no match:
  - all slots shift up by one, and slot 0 loads data_in
  - out_valid <= {out_valid[NUM-2:0],1'b1}
  - count increments, saturating at NUM
  - If out_valid[NUM-1] was 1, then evict_valid_out=1 and evict_data_out=the old slot NUM-1.
- Idle, with in_valid=0: the history holds, and all pulse outputs are 0.
- clear_in=1 has priority over in_valid:
  - out_valid, count, hit_out and evict_valid_out are cleared
  - the input on that cycle is discarded
  - out data is left unchanged; consumers must qualify it with out_valid.
- Invalid slots never produce a match, even when their stale data equals data_in.
- hit_idx_out and evict_data_out hold their last value when their qualifying pulse is 0.

## Timing

- All outputs are registered. An input sampled at edge N appears on the outputs after edge N, giving 1-cycle latency.
- An input is accepted every cycle: there is no backpressure and no ready signal. Back-to-back repeats of the same value give consecutive hit pulses with hit_idx_out=0 after the first.
- The compare at edge N uses the register state before edge N. There is no same-cycle forwarding issue, because the state is only updated at the edge.
- Reset values:
  - out_valid=0, count_out=0, hit_out=0, evict_valid_out=0
  - hit_idx_out=0, evict_data_out=0, out=0
- Reset mid-stream takes effect immediately and asynchronously. The first accepted input after deassertion is a miss.
- Full plus hit: no eviction, and count stays NUM.
- Full plus miss: eviction pulse, and count stays NUM.
- Clear plus in_valid in the same cycle: state is cleared, and no hit or evict pulse is raised.

## Test plan

- Reset, then inputs A,B,C at NUM=4 -> out slots 0..2 = C,B,A; out_valid=4'b0111; count_out=3; hit_out=0 on every cycle.
- Fill with A,B,C,D, then E -> slots 0..3 = E,D,C,B; evict_valid_out=1 with evict_data_out=A; count_out=4.
- From slots D,C,B,A, input B -> slots 0..3 = B,D,C,A; hit_out=1, hit_idx_out=2; no evict; count_out=4. Then input B again -> hit_idx_out=0, and the history is unchanged.
- Clear_in asserted together with in_valid on a full history -> out_valid=0 and count_out=0. Then input the stale value of slot 3 -> it is treated as a miss (hit_out=0), giving out_valid=4'b0001.
- in_valid=0 for 5 cycles between inputs -> no change in out, out_valid or count_out; all pulses 0.
- Assert rst_in asynchronously mid-clock-period during a stream -> all outputs reach their reset values before the next edge. Random stream of 1000 values from a 6-value alphabet at NUM=4, compared against a software move-to-front model -> exact match every cycle.
